// File: rtl/i2c_init_sequencer_if.sv
// Byte-level I2C controller handshake: write word, GO request, END/ACK completion.
// master = init sequencer, slave = I2C controller.
interface i2c_init_sequencer_if;
   logic [23:0] i2cData;
   logic        i2cGo;
   logic        i2cEnd;
   logic        i2cAck;

   modport master (
      output i2cData,
      output i2cGo,
      input  i2cEnd,
      input  i2cAck
   );

   modport slave (
      input  i2cData,
      input  i2cGo,
      output i2cEnd,
      output i2cAck
   );
endinterface

// File: rtl/i2c_init_sequencer.sv
// Power-up register initialiser: walks a {dev, sub, data} table and issues each entry as
// one 3-byte I2C write, with per-entry NACK retry, error counting and re-triggerable runs.
// Optional feature macro: I2C_INIT_DELAY_EN (dev==8'hFF entries become wait commands).
module i2c_init_sequencer #(
   parameter int unsigned CLK_FREQ   = 50000000,
   parameter int unsigned I2C_FREQ   = 20000,
   parameter int unsigned NUM_REGS   = 50,
   parameter int unsigned IDX_W      = 6,
   parameter int unsigned MAX_RETRY  = 3,
   parameter int unsigned AUTO_START = 1
) (
   input  logic                 iCLK,
   input  logic                 iRST_N,
   input  logic                 iSTART,
   output logic                 oTICK,
   output logic [IDX_W-1:0]     oIDX,
   input  logic [23:0]          iENTRY,
   i2c_init_sequencer_if.master i2c,
   output logic                 oBUSY,
   output logic                 oDONE,
   output logic                 oERR,
   output logic [7:0]           oERR_CNT
);

   localparam int unsigned DIV = CLK_FREQ / (2 * I2C_FREQ);
   localparam int unsigned DW  = $clog2(DIV);
   // Wide enough to hold MAX_RETRY, and never zero-width when MAX_RETRY == 0.
   localparam int unsigned RW  = $clog2(MAX_RETRY + 2);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StWait,
      StGap,
      StNext,
      StDone
`ifdef I2C_INIT_DELAY_EN
      , StDelay
`endif
   } stateT;

   stateT            stateQ, stateD;
   logic [DW-1:0]    divCntQ, divCntD;
   logic             startPendQ, startPendD;
   logic [IDX_W-1:0] idxQ, idxD;
   logic [RW-1:0]    retryQ, retryD;
   logic             resendQ, resendD;
   logic [23:0]      dataQ, dataD;
   logic             goQ, goD;
   logic             busyQ, busyD;
   logic             doneQ, doneD;
   logic             errQ, errD;
   logic [7:0]       errCntQ, errCntD;
`ifdef I2C_INIT_DELAY_EN
   logic [31:0]      delayCntQ, delayCntD;
`endif

   logic tick;
   logic startReq;

   assign tick     = (divCntQ == DW'(DIV - 1));
   assign startReq = startPendQ | iSTART;

   // State register; GO and all outputs clear asynchronously on reset.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         stateQ     <= StIdle;
         divCntQ    <= '0;
         startPendQ <= (AUTO_START != 0);
         idxQ       <= '0;
         retryQ     <= '0;
         resendQ    <= 1'b0;
         dataQ      <= '0;
         goQ        <= 1'b0;
         busyQ      <= 1'b0;
         doneQ      <= 1'b0;
         errQ       <= 1'b0;
         errCntQ    <= '0;
`ifdef I2C_INIT_DELAY_EN
         delayCntQ  <= '0;
`endif
      end else begin
         stateQ     <= stateD;
         divCntQ    <= divCntD;
         startPendQ <= startPendD;
         idxQ       <= idxD;
         retryQ     <= retryD;
         resendQ    <= resendD;
         dataQ      <= dataD;
         goQ        <= goD;
         busyQ      <= busyD;
         doneQ      <= doneD;
         errQ       <= errD;
         errCntQ    <= errCntD;
`ifdef I2C_INIT_DELAY_EN
         delayCntQ  <= delayCntD;
`endif
      end
   end

   // Divider, start latch and the sequencing FSM; state moves only on tick cycles.
   always_comb begin
      stateD     = stateQ;
      divCntD    = tick ? '0 : divCntQ + DW'(1);
      startPendD = startPendQ | iSTART;
      idxD       = idxQ;
      retryD     = retryQ;
      resendD    = resendQ;
      dataD      = dataQ;
      goD        = goQ;
      busyD      = busyQ;
      doneD      = doneQ;
      errD       = errQ;
      errCntD    = errCntQ;
`ifdef I2C_INIT_DELAY_EN
      delayCntD  = (delayCntQ != 0) ? delayCntQ - 32'd1 : delayCntQ;
`endif

      if (tick) begin
         // A pending start is consumed at every tick; it only acts when idle.
         startPendD = 1'b0;
         unique case (stateQ)
            StIdle, StDone: begin
               if (startReq) begin
                  idxD    = '0;
                  retryD  = '0;
                  resendD = 1'b0;
                  errD    = 1'b0;
                  errCntD = '0;
                  doneD   = 1'b0;
                  busyD   = 1'b1;
                  stateD  = StLoad;
               end
            end
            StLoad: begin
`ifdef I2C_INIT_DELAY_EN
               if (iENTRY[23:16] == 8'hFF) begin
                  delayCntD = 32'(iENTRY[7:0]) * (CLK_FREQ / 1000);
                  stateD    = StDelay;
               end else begin
                  dataD  = iENTRY;
                  goD    = 1'b1;
                  stateD = StWait;
               end
`else
               dataD  = iENTRY;
               goD    = 1'b1;
               stateD = StWait;
`endif
            end
            StWait: begin
               if (i2c.i2cEnd) begin
                  goD    = 1'b0;
                  stateD = StGap;
                  if (!i2c.i2cAck) begin
                     resendD = 1'b0;
                  end else if (retryQ < RW'(MAX_RETRY)) begin
                     retryD  = retryQ + RW'(1);
                     resendD = 1'b1;
                  end else begin
                     resendD = 1'b0;
                     errD    = 1'b1;
                     if (errCntQ != 8'hFF) errCntD = errCntQ + 8'd1;
                  end
               end
            end
            StGap: begin
               if (!i2c.i2cEnd) stateD = resendQ ? StLoad : StNext;
            end
            StNext: begin
               if (idxQ == IDX_W'(NUM_REGS - 1)) begin
                  busyD  = 1'b0;
                  doneD  = 1'b1;
                  stateD = StDone;
               end else begin
                  idxD   = idxQ + IDX_W'(1);
                  retryD = '0;
                  stateD = StLoad;
               end
            end
`ifdef I2C_INIT_DELAY_EN
            StDelay: begin
               if (delayCntQ == 0) stateD = StNext;
            end
`endif
            default: stateD = StIdle;
         endcase
      end
   end

   assign oTICK       = tick;
   assign oIDX        = idxQ;
   assign i2c.i2cData = dataQ;
   assign i2c.i2cGo   = goQ;
   assign oBUSY       = busyQ;
   assign oDONE       = doneQ;
   assign oERR        = errQ;
   assign oERR_CNT    = errCntQ;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Scoreboard bench for i2c_init_sequencer: expected GO words are queued by the stimulus and
// popped by a monitor on every GO rising edge; a behavioural controller answers END/ACK.
module tb_i2c_init_sequencer;
   localparam int unsigned LAT = 2;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        start  = 1'b0;
   logic        tick;
   logic [1:0]  idx;
   logic [23:0] entry;
   logic        busy;
   logic        done;
   logic        err;
   logic [7:0]  errCnt;

   logic [23:0] tbl [4];
   int unsigned nackLeft [4];
   logic [23:0] expQ [$];
   int unsigned goTime [$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc    = 0;

   i2c_init_sequencer_if bus ();

   assign entry = tbl[idx];

   i2c_init_sequencer #(
      .CLK_FREQ   (1000),
      .I2C_FREQ   (100),
      .NUM_REGS   (4),
      .IDX_W      (2),
      .MAX_RETRY  (2),
      .AUTO_START (1)
   ) dut (
      .iCLK     (clk),
      .iRST_N   (rst_n),
      .iSTART   (start),
      .oTICK    (tick),
      .oIDX     (idx),
      .iENTRY   (entry),
      .i2c      (bus.master),
      .oBUSY    (busy),
      .oDONE    (done),
      .oERR     (err),
      .oERR_CNT (errCnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every GO rising edge must match the head of the expected queue.
   initial begin
      logic goPrev;
      logic [23:0] want;
      goPrev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            goPrev = 1'b0;
         end else begin
            if (bus.i2cGo && !goPrev) begin
               goTime.push_back(cyc);
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_go: got %0h, expected no transfer", bus.i2cData);
               end else begin
                  want = expQ.pop_front();
                  check("go_data", 32'(bus.i2cData), 32'(want));
               end
            end
            goPrev = bus.i2cGo;
         end
      end
   end

   // Controller model: END after LAT cycles of GO, NACK while nackLeft is non-zero (255 = forever).
   initial begin
      int cnt;
      cnt = 0;
      bus.i2cEnd = 1'b0;
      bus.i2cAck = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            bus.i2cEnd = 1'b0;
            cnt = 0;
         end else if (bus.i2cGo && !bus.i2cEnd) begin
            cnt++;
            if (cnt >= LAT) begin
               cnt = 0;
               bus.i2cEnd = 1'b1;
               if (nackLeft[idx] > 0) begin
                  bus.i2cAck = 1'b1;
                  if (nackLeft[idx] != 255) nackLeft[idx]--;
               end else begin
                  bus.i2cAck = 1'b0;
               end
            end
         end else if (!bus.i2cGo && bus.i2cEnd) begin
            bus.i2cEnd = 1'b0;
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_busy(input string name);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (busy) break;
      end
      check(name, 32'(busy), 32'd1);
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done) break;
      end
      check(name, 32'(done), 32'd1);
   endtask

   task automatic push_all();
      for (int i = 0; i < 4; i++) expQ.push_back(tbl[i]);
   endtask

   initial begin
      tbl[0] = 24'h3A_10_01;
      tbl[1] = 24'h3A_22_5C;
      tbl[2] = 24'h40_07_A5;
      tbl[3] = 24'h40_FF_00;
      for (int i = 0; i < 4; i++) nackLeft[i] = 0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_go", 32'(bus.i2cGo), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_errcnt", 32'(errCnt), 32'd0);
      check("rst_idx", 32'(idx), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);

      // 1: auto start, all ACK
      push_all();
      rst_n = 1'b1;
      wait_busy("t1_busy");
      wait_done("t1_done");
      check("t1_busy_end", 32'(busy), 32'd0);
      check("t1_errcnt", 32'(errCnt), 32'd0);
      check("t1_err", 32'(err), 32'd0);
      check("t1_queue_empty", 32'(expQ.size()), 32'd0);

      // 2: entry 1 NACKed twice then ACKed; a busy-time start is ignored
      nackLeft[1] = 2;
      expQ.push_back(tbl[0]);
      repeat (3) expQ.push_back(tbl[1]);
      expQ.push_back(tbl[2]);
      expQ.push_back(tbl[3]);
      pulse_start();
      wait_busy("t2_busy");
      check("t2_done_clr", 32'(done), 32'd0);
      repeat (30) @(negedge clk);
      pulse_start();
      wait_done("t2_done");
      check("t2_err", 32'(err), 32'd0);
      check("t2_errcnt", 32'(errCnt), 32'd0);
      check("t2_queue_empty", 32'(expQ.size()), 32'd0);

      // 3: entry 2 always NACKed -> 3 sends then skipped
      nackLeft[2] = 255;
      expQ.push_back(tbl[0]);
      expQ.push_back(tbl[1]);
      repeat (3) expQ.push_back(tbl[2]);
      expQ.push_back(tbl[3]);
      pulse_start();
      wait_busy("t3_busy");
      wait_done("t3_done");
      check("t3_err", 32'(err), 32'd1);
      check("t3_errcnt", 32'(errCnt), 32'd1);
      check("t3_queue_empty", 32'(expQ.size()), 32'd0);
      nackLeft[2] = 0;

      // 4: restart after DONE clears status and restarts at idx 0
      push_all();
      pulse_start();
      wait_busy("t4_busy");
      check("t4_done_clr", 32'(done), 32'd0);
      check("t4_errcnt_clr", 32'(errCnt), 32'd0);
      check("t4_err_clr", 32'(err), 32'd0);
      check("t4_idx0", 32'(idx), 32'd0);
      wait_done("t4_done");
      check("t4_queue_empty", 32'(expQ.size()), 32'd0);

      // 5: reset mid-transfer drops GO at once; auto start reruns from idx 0
      push_all();
      pulse_start();
      wait_busy("t5_busy");
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (bus.i2cGo && idx == 2'd1) break;
      end
      check("t5_go_seen", 32'(bus.i2cGo), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_go_async", 32'(bus.i2cGo), 32'd0);
      check("t5_busy_async", 32'(busy), 32'd0);
      check("t5_idx_async", 32'(idx), 32'd0);
      repeat (3) @(negedge clk);
      expQ.delete();
      push_all();
      rst_n = 1'b1;
      wait_busy("t5_busy_again");
      wait_done("t5_done");
      check("t5_queue_empty", 32'(expQ.size()), 32'd0);

      // 6: dev==FF entry: wait command with the delay feature, ordinary write without it
      tbl[2] = 24'hFF_00_03;
      goTime.delete();
      expQ.push_back(tbl[0]);
      expQ.push_back(tbl[1]);
`ifndef I2C_INIT_DELAY_EN
      expQ.push_back(tbl[2]);
`endif
      expQ.push_back(tbl[3]);
      pulse_start();
      wait_busy("t6_busy");
      wait_done("t6_done");
      check("t6_queue_empty", 32'(expQ.size()), 32'd0);
`ifdef I2C_INIT_DELAY_EN
      check("t6_go_count", 32'(goTime.size()), 32'd3);
      if (goTime.size() == 3) begin
         check("t6_delay_min", 32'((goTime[2] - goTime[1]) >= 23), 32'd1);
         check("t6_tick_align", 32'((goTime[2] - goTime[1]) % 5), 32'd0);
      end
`else
      check("t6_go_count", 32'(goTime.size()), 32'd4);
      if (goTime.size() == 4) begin
         check("t6_gap_entry", 32'(goTime[3] - goTime[2]), 32'd20);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
